// File: rtl/compactor_pkg.sv
// Shared types and constants for the signature compactor.
// COMPACTOR_PARITY_EN appends an even-parity bit to every unload.
package compactor_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;

    function automatic int unsigned unload_len(input int unsigned sig_width);
`ifdef COMPACTOR_PARITY_EN
        return sig_width + 1;
`else
        return sig_width;
`endif
    endfunction

endpackage

// File: rtl/xor_fold.sv
// Folds a wide bus onto SIG_WIDTH bits: bit i lands on position i mod SIG_WIDTH.
module xor_fold #(
    parameter int unsigned WIDTH     = 729,
    parameter int unsigned SIG_WIDTH = 32
) (
    input  logic [WIDTH-1:0]     i_data,
    output logic [SIG_WIDTH-1:0] o_fold
);

    always_comb begin
        o_fold = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            o_fold[i % int'(SIG_WIDTH)] = o_fold[i % int'(SIG_WIDTH)] ^ i_data[i];
        end
    end

endmodule

// File: rtl/signature_compactor.sv
// MISR compactor for a wide output bus with a serial, MSB-first signature unload.
// Optional feature macro: COMPACTOR_PARITY_EN (adds a trailing even-parity bit).
module signature_compactor
    import compactor_pkg::*;
#(
    parameter int unsigned           WIDTH     = 729,
    parameter int unsigned           SIG_WIDTH = 32,
    parameter logic [SIG_WIDTH-1:0]  TAPS      = SIG_WIDTH'(DEFAULT_TAPS),
    parameter logic [SIG_WIDTH-1:0]  SEED      = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_capture_en,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic             i_unload,
    output logic             o_sig_out,
    output logic             o_sig_valid,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned SNAP_W = unload_len(SIG_WIDTH);
    localparam int unsigned CNT_W  = $clog2(SNAP_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SNAP_W - 1);

    logic [SIG_WIDTH-1:0] r_sig;
    logic [SIG_WIDTH-1:0] w_fold;
    logic [SIG_WIDTH-1:0] w_sig_next;
    logic [SNAP_W-1:0]    r_snap;
    logic [SNAP_W-1:0]    w_snap_d;
    logic [SNAP_W-1:0]    w_snap_load;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_d;
    state_e               r_state;
    state_e               w_state_d;

    xor_fold #(
        .WIDTH     (WIDTH),
        .SIG_WIDTH (SIG_WIDTH)
    ) u_xor_fold (
        .i_data (i_data_in),
        .o_fold (w_fold)
    );

    assign w_sig_next = {r_sig[SIG_WIDTH-2:0], ^(r_sig & TAPS)} ^ w_fold;

`ifdef COMPACTOR_PARITY_EN
    assign w_snap_load = {r_sig, ^r_sig};
`else
    assign w_snap_load = r_sig;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sig <= SEED;
        end else if (i_clr) begin
            r_sig <= SEED;
        end else if (i_capture_en) begin
            r_sig <= w_sig_next;
        end
    end

    // Snapshot uses the pre-update r_sig, so a same-cycle capture never leaks in.
    always_comb begin
        w_state_d = r_state;
        w_snap_d  = r_snap;
        w_cnt_d   = r_cnt;
        if (i_clr) begin
            w_state_d = StIdle;
            w_snap_d  = '0;
            w_cnt_d   = '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_unload) begin
                        w_snap_d  = w_snap_load;
                        w_cnt_d   = CNT_LAST;
                        w_state_d = StShift;
                    end
                end
                StShift: begin
                    w_snap_d = {r_snap[SNAP_W-2:0], 1'b0};
                    if (r_cnt == '0) begin
                        w_state_d = StDone;
                    end else begin
                        w_cnt_d = r_cnt - 1'b1;
                    end
                end
                StDone:  w_state_d = StIdle;
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_snap  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_snap  <= w_snap_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Outputs decode registered state only; no input reaches them combinationally.
    assign o_busy      = (r_state == StShift);
    assign o_sig_valid = (r_state == StShift);
    assign o_sig_out   = o_sig_valid & r_snap[SNAP_W-1];
    assign o_done      = (r_state == StDone);

endmodule
